// File: rtl/conv_ser_par_n_if.sv
// Word-side handshake bundle of the serial-to-parallel receiver.
// The master drives the received word and its flags; the slave drives ready.
interface conv_ser_par_n_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] d;
  logic             valid;
  logic             ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  modport master (
    output d,
    output valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  d,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/conv_ser_par_n.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits, optional parity, STOP_BITS stop bits.
// Completed frames are offered on a valid/ready port; a frame that finds the port full is dropped.
module conv_ser_par_n #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  output logic                    busy,
  conv_ser_par_n_if.master        bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);
  localparam bit ParEn  = (PARITY_EN != 0);
  localparam bit ParOdd = (PARITY_ODD != 0);
  localparam bit MsbFirst = (MSB_FIRST != 0);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StWaitIdle} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_acc_q, par_acc_d;
  logic             ferr_acc_q, ferr_acc_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             overrun_q, overrun_d;
  logic             accept;
  logic             complete;
  logic             ferr_now;
  logic [WIDTH:0]   ext;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    ferr_acc_d = ferr_acc_q;
    d_d        = d_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = 1'b0;
    complete   = 1'b0;
    ferr_now   = ferr_acc_q;
    ext        = '0;
    accept     = valid_q && bus.ready;

    if (accept) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        shift_d    = '0;
        par_acc_d  = 1'b0;
        ferr_acc_d = 1'b0;
        if (!in) state_d = StData;
      end
      StData: begin
        // Widen by one bit so the shift works for WIDTH == 1 too.
        if (MsbFirst) begin
          ext     = {shift_q, in};
          shift_d = ext[WIDTH-1:0];
        end else begin
          ext     = {in, shift_q};
          shift_d = ext[WIDTH:1];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = ParEn ? StParity : StStop;
        end
      end
      StParity: begin
        par_acc_d = ((^shift_q) ^ in) != ParOdd;
        state_d   = StStop;
      end
      StStop: begin
        ferr_now   = ferr_acc_q | ~in;
        ferr_acc_d = ferr_now;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LastStop) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = ferr_now ? StWaitIdle : StIdle;
        end
      end
      StWaitIdle: begin
        if (in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Acceptance in the completion cycle frees the slot for the new frame.
    if (complete) begin
      if (!valid_q || accept) begin
        d_d     = shift_q;
        perr_d  = ParEn ? par_acc_q : 1'b0;
        ferr_d  = ferr_now;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      ferr_acc_q <= ferr_acc_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign bus.d          = d_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;

endmodule
